trigger_capture_window: RTL and testbench
=========================================

Name: trigger_capture_window

Overview:
Sits directly downstream of the signed level-trigger stage. It consumes that stage's trigger event and DMA address, and turns it into a complete acquisition frame. Run order: arm, collect the pre-trigger history, wait for the trigger, count the post-trigger samples, then report the frame start address within the circular DMA buffer. The frame stays reported until software acknowledges it.

Parameters:
MEMORY_ADDR_LEN, 32, width of DMA addresses
BYTES_PER_SAMPLE, 2, address increment per valid sample (DATA_WIDTH/8)
CNT_WIDTH, 16, width of the pre/post sample counters

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
arm  in  1  one-cycle start request from control registers
ack  in  1  one-cycle acknowledge of a completed frame
in_data_valid  in  1  sample strobe; same strobe that feeds the trigger stage
in_dma_master_address  in  MEMORY_ADDR_LEN  current DMA write address
trig_valid  in  1  one-cycle trigger-fire pulse from the trigger stage
trig_addr  in  MEMORY_ADDR_LEN  DMA address captured at the trigger
buf_base  in  MEMORY_ADDR_LEN  circular buffer base byte address
buf_len  in  MEMORY_ADDR_LEN  circular buffer length in bytes, a multiple of BYTES_PER_SAMPLE
pre_samples  in  CNT_WIDTH  samples kept before the trigger
post_samples  in  CNT_WIDTH  samples captured after the trigger, including the trigger sample
frame_start_addr  out  MEMORY_ADDR_LEN  first byte address of the frame
frame_trig_addr  out  MEMORY_ADDR_LEN  latched trigger address
capture_done  out  1  level signal: frame ready, held until ack
capture_irq  out  1  one-cycle pulse when capture_done rises
cfg_error  out  1  sticky error: configuration rejected at arm
state_dbg  out  3  encoded current state

Behaviour:
- Reset is asynchronous and active-high. On reset every output is 0, state is IDLE and all counters are 0.
- Configuration is latched on the arm cycle. Configuration changes after arm are ignored until the next arm.
- Config check at arm:
  - Reject if (pre_samples + post_samples) * BYTES_PER_SAMPLE > buf_len, or buf_len == 0, or post_samples == 0.
  - On reject: set cfg_error, remain in IDLE.
  - On a valid arm: clear cfg_error.
- States (encoding IDLE=0, FILL=1, ARMED=2, POST=3, DONE=4):
  - IDLE: arm -> FILL. The pre counter loads 0.
  - FILL: counts valid samples. When count == pre_samples -> ARMED. If pre_samples == 0, go straight to ARMED on the cycle after arm.
  - FILL: trig_valid is ignored, so the frame always has full history.
  - ARMED: on trig_valid -> latch trig_addr into frame_trig_addr, load the post counter with 1, go to POST.
  - ARMED: if post_samples == 1, go straight to DONE.
  - POST: each in_data_valid increments the post counter. On the valid where the counter reaches post_samples -> DONE.
  - POST: further trig_valid pulses are ignored.
  - DONE: capture_done = 1. ack -> IDLE with capture_done cleared the next cycle.
  - DONE: arm without ack is ignored; ack has priority over a simultaneous arm.
- capture_irq is high exactly one cycle, on the first DONE cycle.
- frame_start_addr is registered on the ARMED->POST transition.
  - pre_bytes = pre_samples * BYTES_PER_SAMPLE; off = trig_addr - buf_base.
  - If off >= pre_bytes: start = trig_addr - pre_bytes.
  - Otherwise: start = trig_addr + buf_len - pre_bytes (wrap-around).
  - Arithmetic is unsigned, MEMORY_ADDR_LEN bits, no overflow beyond the buffer.
- Latency: trig_valid to frame_start_addr stable is 1 cycle. Last post sample to capture_done is 1 cycle.
- A trig_valid and in_data_valid in the same cycle count as the trigger sample only.
- in_dma_master_address is used only for state_dbg-side monitoring. Address math relies solely on trig_addr.
- A reset mid-capture aborts immediately and all outputs return to reset values.

Decomposition:
- Shared package holds:
  - state enum/localparams (IDLE..DONE)
  - BYTES_PER_SAMPLE default
  - state_dbg encoding
- One natural sub-module, circ_addr_sub: combinational wrap-around subtraction (addr, base, len, bytes -> start). It is reused by the DMA readout block.

Test Plan:
- Use buf_base=0x1000, buf_len=0x400, pre=16, post=32, and arm. Feed 16 valids, then trig_valid with trig_addr=0x1100. Expected: frame_start_addr=0x10E0, capture_done after 31 more valids, capture_irq pulses once.
- Wrap case: same config, trig_addr=0x1008. Expected: frame_start_addr=0x13E8.
- Send trig_valid during FILL (after 5 valids). Expected: trigger ignored, state stays FILL, and the first trigger in ARMED is latched.
- Arm with pre=400, post=200, buf_len=0x400 (1200 > 1024 bytes). Expected: cfg_error=1, state IDLE. A subsequent valid arm clears cfg_error.
- In DONE, assert arm and ack in the same cycle. Expected: state IDLE, capture_done=0, no new capture. A later arm starts FILL.
- Assert rst asynchronously mid-POST. Expected: all outputs 0 immediately, state IDLE, and a post-reset capture behaves normally.

Source files
------------

// File: rtl/trigger_capture_window_pkg.sv
// Shared definitions for the trigger capture window: FSM states, the
// state_dbg encoding and the default sample size in bytes.
package trigger_capture_window_pkg;

   localparam int BYTES_PER_SAMPLE_DEF = 2;
   localparam int STATE_W              = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE  = 3'd0,
      ST_FILL  = 3'd1,
      ST_ARMED = 3'd2,
      ST_POST  = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   // state_dbg exposes the raw state encoding so software sees 0..4
   function automatic logic [STATE_W-1:0] state_dbg_enc(input state_e s);
      return s;
   endfunction

endpackage

// File: rtl/trigger_capture_window_circ_addr_sub.sv
// Wrap-around subtraction inside a circular buffer: returns the address
// that lies 'bytes' before 'addr', wrapping back from the buffer base to
// its top. Shared with the DMA readout logic.
module circ_addr_sub
   import trigger_capture_window_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [ADDR_W-1:0] base_i,
   input  logic [ADDR_W-1:0] len_i,
   input  logic [ADDR_W-1:0] bytes_i,
   output logic [ADDR_W-1:0] start_o
);

   logic [ADDR_W-1:0] off;

   // Step back directly when the history fits below addr, otherwise wrap
   always_comb begin
      off = addr_i - base_i;
      if (off >= bytes_i) begin
         start_o = addr_i - bytes_i;
      end else begin
         start_o = addr_i + len_i - bytes_i;
      end
   end

endmodule

// File: rtl/trigger_capture_window.sv
// Turns a trigger event into a complete acquisition frame: arm, collect
// pre-trigger history, wait for the trigger, count post-trigger samples,
// then hold the frame start address until software acknowledges it.
module trigger_capture_window
   import trigger_capture_window_pkg::*;
#(
   parameter int MEMORY_ADDR_LEN  = 32,
   parameter int BYTES_PER_SAMPLE = BYTES_PER_SAMPLE_DEF,
   parameter int CNT_WIDTH        = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       arm,
   input  logic                       ack,
   input  logic                       in_data_valid,
   input  logic [MEMORY_ADDR_LEN-1:0] in_dma_master_address,
   input  logic                       trig_valid,
   input  logic [MEMORY_ADDR_LEN-1:0] trig_addr,
   input  logic [MEMORY_ADDR_LEN-1:0] buf_base,
   input  logic [MEMORY_ADDR_LEN-1:0] buf_len,
   input  logic [CNT_WIDTH-1:0]       pre_samples,
   input  logic [CNT_WIDTH-1:0]       post_samples,
   output logic [MEMORY_ADDR_LEN-1:0] frame_start_addr,
   output logic [MEMORY_ADDR_LEN-1:0] frame_trig_addr,
   output logic                       capture_done,
   output logic                       capture_irq,
   output logic                       cfg_error,
   output logic [2:0]                 state_dbg
);

   // Wide enough that (pre + post) * BYTES_PER_SAMPLE can never overflow
   localparam int NEED_W = CNT_WIDTH + 1 + $clog2(BYTES_PER_SAMPLE + 1);
   localparam int CMP_W  = (NEED_W > MEMORY_ADDR_LEN) ? NEED_W : MEMORY_ADDR_LEN;

   state_e                     state_q, state_d;
   logic [CNT_WIDTH-1:0]       pre_cnt_q, pre_cnt_d;
   logic [CNT_WIDTH-1:0]       post_cnt_q, post_cnt_d;
   logic [CNT_WIDTH-1:0]       pre_cfg_q, pre_cfg_d;
   logic [CNT_WIDTH-1:0]       post_cfg_q, post_cfg_d;
   logic [MEMORY_ADDR_LEN-1:0] base_cfg_q, base_cfg_d;
   logic [MEMORY_ADDR_LEN-1:0] len_cfg_q, len_cfg_d;
   logic [MEMORY_ADDR_LEN-1:0] start_q, start_d;
   logic [MEMORY_ADDR_LEN-1:0] trig_q, trig_d;
   logic                       cfg_error_q, cfg_error_d;
   logic                       irq_q, irq_d;

   logic [CMP_W-1:0]           need_bytes;
   logic                       cfg_bad;
   logic [MEMORY_ADDR_LEN-1:0] pre_bytes;
   logic [MEMORY_ADDR_LEN-1:0] start_calc;

   // The DMA write address is monitoring-only; frame math uses trig_addr
   logic unused_dma_addr;
   assign unused_dma_addr = ^in_dma_master_address;

   // Validate the live configuration presented on the arm cycle
   always_comb begin
      need_bytes = (CMP_W'(pre_samples) + CMP_W'(post_samples)) * CMP_W'(BYTES_PER_SAMPLE);
      cfg_bad    = (need_bytes > CMP_W'(buf_len)) || (buf_len == '0) || (post_samples == '0);
   end

   assign pre_bytes = MEMORY_ADDR_LEN'(pre_cfg_q) * MEMORY_ADDR_LEN'(BYTES_PER_SAMPLE);

   circ_addr_sub #(
      .ADDR_W (MEMORY_ADDR_LEN)
   ) u_circ_addr_sub (
      .addr_i  (trig_addr),
      .base_i  (base_cfg_q),
      .len_i   (len_cfg_q),
      .bytes_i (pre_bytes),
      .start_o (start_calc)
   );

   // Next-state logic for the capture sequence and all tracked registers
   always_comb begin
      state_d     = state_q;
      pre_cnt_d   = pre_cnt_q;
      post_cnt_d  = post_cnt_q;
      pre_cfg_d   = pre_cfg_q;
      post_cfg_d  = post_cfg_q;
      base_cfg_d  = base_cfg_q;
      len_cfg_d   = len_cfg_q;
      start_d     = start_q;
      trig_d      = trig_q;
      cfg_error_d = cfg_error_q;
      irq_d       = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (arm) begin
               if (cfg_bad) begin
                  cfg_error_d = 1'b1;
               end else begin
                  cfg_error_d = 1'b0;
                  pre_cfg_d   = pre_samples;
                  post_cfg_d  = post_samples;
                  base_cfg_d  = buf_base;
                  len_cfg_d   = buf_len;
                  pre_cnt_d   = '0;
                  post_cnt_d  = '0;
                  // No history requested: skip FILL and be armed next cycle
                  state_d     = (pre_samples == '0) ? ST_ARMED : ST_FILL;
               end
            end
         end
         ST_FILL: begin
            // Triggers are ignored here so every frame has full history
            if (in_data_valid) begin
               pre_cnt_d = pre_cnt_q + CNT_WIDTH'(1);
               if (pre_cnt_d == pre_cfg_q) begin
                  state_d = ST_ARMED;
               end
            end
         end
         ST_ARMED: begin
            // A simultaneous valid is the trigger sample itself, counted once
            if (trig_valid) begin
               trig_d     = trig_addr;
               start_d    = start_calc;
               post_cnt_d = CNT_WIDTH'(1);
               if (post_cfg_q == CNT_WIDTH'(1)) begin
                  state_d = ST_DONE;
                  irq_d   = 1'b1;
               end else begin
                  state_d = ST_POST;
               end
            end
         end
         ST_POST: begin
            if (in_data_valid) begin
               post_cnt_d = post_cnt_q + CNT_WIDTH'(1);
               if (post_cnt_d == post_cfg_q) begin
                  state_d = ST_DONE;
                  irq_d   = 1'b1;
               end
            end
         end
         ST_DONE: begin
            // Only ack leaves DONE; arm is ignored until then
            if (ack) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers, cleared immediately by rst
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         pre_cnt_q   <= '0;
         post_cnt_q  <= '0;
         pre_cfg_q   <= '0;
         post_cfg_q  <= '0;
         base_cfg_q  <= '0;
         len_cfg_q   <= '0;
         start_q     <= '0;
         trig_q      <= '0;
         cfg_error_q <= 1'b0;
         irq_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         pre_cnt_q   <= pre_cnt_d;
         post_cnt_q  <= post_cnt_d;
         pre_cfg_q   <= pre_cfg_d;
         post_cfg_q  <= post_cfg_d;
         base_cfg_q  <= base_cfg_d;
         len_cfg_q   <= len_cfg_d;
         start_q     <= start_d;
         trig_q      <= trig_d;
         cfg_error_q <= cfg_error_d;
         irq_q       <= irq_d;
      end
   end

   assign frame_start_addr = start_q;
   assign frame_trig_addr  = trig_q;
   assign capture_done     = (state_q == ST_DONE);
   assign capture_irq      = irq_q;
   assign cfg_error        = cfg_error_q;
   assign state_dbg        = state_dbg_enc(state_q);

endmodule

// File: tb/tb_trigger_capture_window.sv
// Testbench for trigger_capture_window: scenario tasks with inline checks
// and a frame scoreboard popped on every capture_irq.
module tb_trigger_capture_window;

   localparam int AW = 32;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          arm = 1'b0;
   logic          ack = 1'b0;
   logic          in_data_valid = 1'b0;
   logic [AW-1:0] in_dma_master_address = '0;
   logic          trig_valid = 1'b0;
   logic [AW-1:0] trig_addr = '0;
   logic [AW-1:0] buf_base = '0;
   logic [AW-1:0] buf_len = '0;
   logic [CW-1:0] pre_samples = '0;
   logic [CW-1:0] post_samples = '0;
   logic [AW-1:0] frame_start_addr;
   logic [AW-1:0] frame_trig_addr;
   logic          capture_done;
   logic          capture_irq;
   logic          cfg_error;
   logic [2:0]    state_dbg;

   typedef struct packed {
      logic [AW-1:0] start;
      logic [AW-1:0] trig;
   } frame_t;

   frame_t exp_q[$];
   frame_t mon_e;
   int     checks = 0;
   int     errors = 0;
   int     irq_seen = 0;
   int     pushed = 0;

   trigger_capture_window #(
      .MEMORY_ADDR_LEN  (AW),
      .BYTES_PER_SAMPLE (2),
      .CNT_WIDTH        (CW)
   ) dut (
      .clk                   (clk),
      .rst                   (rst),
      .arm                   (arm),
      .ack                   (ack),
      .in_data_valid         (in_data_valid),
      .in_dma_master_address (in_dma_master_address),
      .trig_valid            (trig_valid),
      .trig_addr             (trig_addr),
      .buf_base              (buf_base),
      .buf_len               (buf_len),
      .pre_samples           (pre_samples),
      .post_samples          (post_samples),
      .frame_start_addr      (frame_start_addr),
      .frame_trig_addr       (frame_trig_addr),
      .capture_done          (capture_done),
      .capture_irq           (capture_irq),
      .cfg_error             (cfg_error),
      .state_dbg             (state_dbg)
   );

   always #5 clk = ~clk;

   // Scoreboard: every irq pulse must match the oldest expected frame
   always @(negedge clk) begin
      if (!rst && capture_irq) begin
         irq_seen++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected_irq: got irq with %0d frames expected, required 1", exp_q.size());
         end else begin
            mon_e = exp_q.pop_front();
            checks++;
            if (frame_start_addr !== mon_e.start || frame_trig_addr !== mon_e.trig) begin
               errors++;
               $display("FAIL sb_frame: got start=%h trig=%h, required start=%h trig=%h",
                        frame_start_addr, frame_trig_addr, mon_e.start, mon_e.trig);
            end else begin
               $display("frame: start=%h trig=%h", frame_start_addr, frame_trig_addr);
            end
         end
      end
   end

   // ---------------- stimulus helpers (no checking) ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_arm(input logic [AW-1:0] base, input logic [AW-1:0] len,
                         input logic [CW-1:0] pre, input logic [CW-1:0] post);
      buf_base     = base;
      buf_len      = len;
      pre_samples  = pre;
      post_samples = post;
      arm          = 1'b1;
      tick();
      arm          = 1'b0;
   endtask

   task automatic feed(input int n);
      in_data_valid = 1'b1;
      for (int i = 0; i < n; i++) begin
         tick();
         in_dma_master_address = in_dma_master_address + 32'd2;
      end
      in_data_valid = 1'b0;
   endtask

   task automatic fire(input logic [AW-1:0] a, input logic with_valid);
      trig_valid    = 1'b1;
      trig_addr     = a;
      in_data_valid = with_valid;
      tick();
      trig_valid    = 1'b0;
      in_data_valid = 1'b0;
   endtask

   task automatic push_exp(input logic [AW-1:0] s, input logic [AW-1:0] t);
      frame_t f;
      f.start = s;
      f.trig  = t;
      exp_q.push_back(f);
      pushed++;
   endtask

   task automatic do_ack();
      ack = 1'b1;
      tick();
      ack = 1'b0;
   endtask

   // Complete a 16/32 capture from the FILL state and acknowledge it
   task automatic full_capture(input logic [AW-1:0] t, input logic [AW-1:0] s);
      feed(16);
      push_exp(s, t);
      fire(t, 1'b0);
      feed(31);
      do_ack();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      #1 rst = 1'b1;
      tick();
      tick();
      checks++;
      if ({frame_start_addr, frame_trig_addr, capture_done, capture_irq, cfg_error, state_dbg} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got start=%h trig=%h done=%b irq=%b err=%b st=%0d, required all 0",
                  frame_start_addr, frame_trig_addr, capture_done, capture_irq, cfg_error, state_dbg);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      do_arm(32'h1000, 32'h400, 16'd16, 16'd32);
      checks++;
      if (state_dbg !== 3'd1) begin errors++; $display("FAIL basic_fill: got %0d, required 1", state_dbg); end
      // Config changes after arm must have no effect
      pre_samples = 16'd3; post_samples = 16'd5; buf_base = '0; buf_len = '0;
      feed(15);
      checks++;
      if (state_dbg !== 3'd1) begin errors++; $display("FAIL basic_fill15: got %0d, required 1", state_dbg); end
      feed(1);
      checks++;
      if (state_dbg !== 3'd2) begin errors++; $display("FAIL basic_armed: got %0d, required 2", state_dbg); end
      push_exp(32'h10E0, 32'h1100);
      fire(32'h1100, 1'b0);
      checks++;
      if (state_dbg !== 3'd3) begin errors++; $display("FAIL basic_post: got %0d, required 3", state_dbg); end
      checks++;
      if (frame_start_addr !== 32'h10E0) begin errors++; $display("FAIL basic_start: got %h, required %h", frame_start_addr, 32'h10E0); end
      checks++;
      if (frame_trig_addr !== 32'h1100) begin errors++; $display("FAIL basic_trig: got %h, required %h", frame_trig_addr, 32'h1100); end
      feed(30);
      checks++;
      if (capture_done !== 1'b0) begin errors++; $display("FAIL basic_early_done: got %b, required 0", capture_done); end
      feed(1);
      checks++;
      if (capture_done !== 1'b1 || capture_irq !== 1'b1) begin
         errors++; $display("FAIL basic_done: got done=%b irq=%b, required 1 1", capture_done, capture_irq);
      end
      tick();
      checks++;
      if (capture_done !== 1'b1 || capture_irq !== 1'b0) begin
         errors++; $display("FAIL basic_irq_once: got done=%b irq=%b, required 1 0", capture_done, capture_irq);
      end
      do_ack();
      checks++;
      if (state_dbg !== 3'd0 || capture_done !== 1'b0) begin
         errors++; $display("FAIL basic_ack: got st=%0d done=%b, required 0 0", state_dbg, capture_done);
      end
   endtask

   task automatic test_wrap();
      do_arm(32'h1000, 32'h400, 16'd16, 16'd32);
      feed(16);
      push_exp(32'h13E8, 32'h1008);
      fire(32'h1008, 1'b1);   // trigger with a coincident valid counts once
      checks++;
      if (frame_start_addr !== 32'h13E8) begin errors++; $display("FAIL wrap_start: got %h, required %h", frame_start_addr, 32'h13E8); end
      feed(30);
      checks++;
      if (capture_done !== 1'b0) begin errors++; $display("FAIL wrap_trig_counted_once: got done=%b, required 0", capture_done); end
      feed(1);
      checks++;
      if (capture_done !== 1'b1) begin errors++; $display("FAIL wrap_done: got %b, required 1", capture_done); end
      do_ack();
   endtask

   task automatic test_trig_in_fill();
      do_arm(32'h1000, 32'h400, 16'd16, 16'd32);
      feed(5);
      fire(32'h1200, 1'b0);
      checks++;
      if (state_dbg !== 3'd1) begin errors++; $display("FAIL fill_trig_ignored: got %0d, required 1", state_dbg); end
      feed(11);
      checks++;
      if (state_dbg !== 3'd2) begin errors++; $display("FAIL fill_then_armed: got %0d, required 2", state_dbg); end
      push_exp(32'h10E0, 32'h1100);
      fire(32'h1100, 1'b0);
      checks++;
      if (frame_trig_addr !== 32'h1100) begin errors++; $display("FAIL fill_latched_trig: got %h, required %h", frame_trig_addr, 32'h1100); end
      fire(32'h1300, 1'b0);   // retrigger during POST must not move the frame
      checks++;
      if (frame_trig_addr !== 32'h1100) begin errors++; $display("FAIL post_retrig: got %h, required %h", frame_trig_addr, 32'h1100); end
      feed(31);
      do_ack();
   endtask

   task automatic test_cfg_error();
      do_arm(32'h1000, 32'h400, 16'd400, 16'd200);
      checks++;
      if (cfg_error !== 1'b1 || state_dbg !== 3'd0) begin
         errors++; $display("FAIL cfg_oversize: got err=%b st=%0d, required 1 0", cfg_error, state_dbg);
      end
      tick();
      checks++;
      if (cfg_error !== 1'b1) begin errors++; $display("FAIL cfg_sticky: got %b, required 1", cfg_error); end
      do_arm(32'h1000, 32'h0, 16'd16, 16'd32);
      checks++;
      if (state_dbg !== 3'd0) begin errors++; $display("FAIL cfg_len_zero: got st=%0d, required 0", state_dbg); end
      do_arm(32'h1000, 32'h400, 16'd16, 16'd0);
      checks++;
      if (state_dbg !== 3'd0) begin errors++; $display("FAIL cfg_post_zero: got st=%0d, required 0", state_dbg); end
      do_arm(32'h1000, 32'h40, 16'd16, 16'd17);
      checks++;
      if (state_dbg !== 3'd0) begin errors++; $display("FAIL cfg_over_by_one: got st=%0d, required 0", state_dbg); end
      // Exact fit (64 bytes into 64) is accepted and clears the error
      do_arm(32'h1000, 32'h40, 16'd16, 16'd16);
      checks++;
      if (cfg_error !== 1'b0 || state_dbg !== 3'd1) begin
         errors++; $display("FAIL cfg_exact_fit: got err=%b st=%0d, required 0 1", cfg_error, state_dbg);
      end
      feed(16);
      push_exp(32'h1030, 32'h1010);
      fire(32'h1010, 1'b0);
      checks++;
      if (frame_start_addr !== 32'h1030) begin errors++; $display("FAIL small_wrap_start: got %h, required %h", frame_start_addr, 32'h1030); end
      feed(15);
      checks++;
      if (capture_done !== 1'b1) begin errors++; $display("FAIL small_done: got %b, required 1", capture_done); end
      do_ack();
   endtask

   task automatic test_post_one();
      do_arm(32'h1000, 32'h400, 16'd0, 16'd1);
      checks++;
      if (state_dbg !== 3'd2) begin errors++; $display("FAIL pre0_armed: got %0d, required 2", state_dbg); end
      push_exp(32'h1100, 32'h1100);
      fire(32'h1100, 1'b0);
      checks++;
      if (state_dbg !== 3'd4 || capture_irq !== 1'b1) begin
         errors++; $display("FAIL post1_done: got st=%0d irq=%b, required 4 1", state_dbg, capture_irq);
      end
      do_ack();
   endtask

   task automatic test_back_to_back_ack_arm();
      do_arm(32'h1000, 32'h400, 16'd16, 16'd32);
      feed(16);
      push_exp(32'h10E0, 32'h1100);
      fire(32'h1100, 1'b0);
      feed(31);
      arm = 1'b1;
      tick();
      arm = 1'b0;
      checks++;
      if (state_dbg !== 3'd4 || capture_done !== 1'b1) begin
         errors++; $display("FAIL done_arm_ignored: got st=%0d done=%b, required 4 1", state_dbg, capture_done);
      end
      arm = 1'b1;
      ack = 1'b1;
      tick();
      arm = 1'b0;
      ack = 1'b0;
      checks++;
      if (state_dbg !== 3'd0 || capture_done !== 1'b0) begin
         errors++; $display("FAIL ack_over_arm: got st=%0d done=%b, required 0 0", state_dbg, capture_done);
      end
      tick();
      tick();
      checks++;
      if (state_dbg !== 3'd0) begin errors++; $display("FAIL no_new_capture: got %0d, required 0", state_dbg); end
      do_arm(32'h1000, 32'h400, 16'd16, 16'd32);
      checks++;
      if (state_dbg !== 3'd1) begin errors++; $display("FAIL rearm_fill: got %0d, required 1", state_dbg); end
      full_capture(32'h1100, 32'h10E0);
   endtask

   task automatic test_async_reset();
      do_arm(32'h1000, 32'h400, 16'd16, 16'd32);
      feed(16);
      push_exp(32'h10E0, 32'h1100);
      fire(32'h1100, 1'b0);
      feed(10);
      checks++;
      if (state_dbg !== 3'd3) begin errors++; $display("FAIL midpost_state: got %0d, required 3", state_dbg); end
      // This frame is aborted, so it must never be reported
      void'(exp_q.pop_back());
      pushed--;
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({frame_start_addr, frame_trig_addr, capture_done, capture_irq, cfg_error, state_dbg} !== '0) begin
         errors++;
         $display("FAIL async_reset: got start=%h trig=%h done=%b irq=%b err=%b st=%0d, required all 0",
                  frame_start_addr, frame_trig_addr, capture_done, capture_irq, cfg_error, state_dbg);
      end
      tick();
      rst = 1'b0;
      tick();
      do_arm(32'h1000, 32'h400, 16'd16, 16'd32);
      checks++;
      if (state_dbg !== 3'd1) begin errors++; $display("FAIL post_reset_arm: got %0d, required 1", state_dbg); end
      full_capture(32'h1008, 32'h13E8);
      checks++;
      if (state_dbg !== 3'd0) begin errors++; $display("FAIL post_reset_idle: got %0d, required 0", state_dbg); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_trig_in_fill();
      test_cfg_error();
      test_post_one();
      test_back_to_back_ack_arm();
      test_async_reset();
      tick();
      tick();
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d pending frames, required 0", exp_q.size()); end
      checks++;
      if (irq_seen != pushed) begin errors++; $display("FAIL irq_count: got %0d, required %0d", irq_seen, pushed); end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
